count_result_checker: RTL and testbench
=======================================

// Module: count_result_checker
// PURPOSE
// - Reader side of the 24-bit counter result buses: samples one free-running result bus each clk,
//   checks it advances by exactly +1 (mod 2**WIDTH) and returns to RESET_VALUE under DUT reset.
// - Sits beside the reset-style counter blocks; one instance per result bus; outputs feed status/LEDs.
// PARAMETERS
// - WIDTH        24   result bus width
// - RESET_VALUE  0    value the observed counter must hold while its reset is applied
// - ERR_CNT_W    16   width of saturating error counter
// - STOP_ON_ERR  0    1: enter FAIL on first mismatch and stop checking; 0: resync and keep checking
// PORTS
// - clk             in   1          system clock, all logic on rising edge
// - rst             in   1          synchronous, active-high reset of this checker
// - en              in   1          check enable; low forces IDLE
// - dut_rst_active  in   1          1 while the observed counter's reset is asserted (either polarity, already decoded)
// - result          in   WIDTH      observed counter value
// - locked          out  1          1 in TRACK state
// - err_pulse       out  1          one-cycle pulse per detected mismatch
// - err_count       out  ERR_CNT_W  saturating mismatch count
// - bad_value       out  WIDTH      last mismatching sample
// - exp_value       out  WIDTH      expected value for that mismatch
// - fail            out  1          sticky, STOP_ON_ERR=1 only
// BEHAVIOUR
// - Reset (clk edge with rst=1): state=IDLE; all outputs 0; prev sample register 0. rst wins over every other input.
// - States: IDLE, SYNC, TRACK, RSTCHK, FAIL.
//   IDLE:   en=1 -> SYNC.
//   SYNC:   capture result into prev; next cycle -> TRACK (no check on the capture cycle).
//   TRACK:  expected = prev+1, wrap 2**WIDTH-1 -> 0 (WIDTH-bit add, carry dropped). Mismatch -> err_pulse,
//           err_count++, bad_value/exp_value updated; then SYNC (STOP_ON_ERR=0) or FAIL (=1). prev <= result every cycle.
//   RSTCHK: entered from TRACK/SYNC when dut_rst_active=1. First cycle after entry is don't-care (covers sync
//           vs async latency); from second cycle on result must equal RESET_VALUE, else mismatch as above
//           with exp_value=RESET_VALUE. dut_rst_active=0 -> SYNC (first post-release value is re-captured).
//   FAIL:   fail=1, locked=0, outputs frozen; exit only via rst.
// - en=0 in any state except FAIL -> IDLE next cycle; err_count/bad_value/exp_value retained.
// - Simultaneous dut_rst_active rise and TRACK mismatch in same cycle: reset takes priority, no error.
// - err_count saturates at all-ones; err_pulse still fires.
// - Latency: err_pulse asserts the cycle after the offending sample is on result.
// - locked=1 only in TRACK; 0 in SYNC, RSTCHK, IDLE, FAIL.
// STRUCTURE
// - Shared package: state enum typedef (checker_state_t), default WIDTH/RESET_VALUE constants used by counter blocks.
// - One sub-module: sat_counter (parameterised width, inc input, saturating) for err_count.
// - Rest is flat: FSM, prev/expected register, +1 comparator.
// TESTING
// - Clean ramp 0..1000 with en=1 -> locked=1 from cycle 2 after en, err_count=0.
// - Wrap: ramp 0xFFFFFD..0x000002 -> no err_pulse, locked stays 1 across 0xFFFFFF->0x000000.
// - Skip: inject 5,6,8 -> one err_pulse, bad_value=8, exp_value=7, err_count=1, relock after 2 cycles.
// - DUT reset: dut_rst_active=1 for 4 cycles, result=0 from cycle 2 -> no error; result=3 on cycle 3 -> error, exp_value=0.
// - STOP_ON_ERR=1: one skip -> fail=1, further skips do not change err_count; rst clears all to 0.
// - Saturation with ERR_CNT_W=2: 5 mismatches -> err_count=3, 5 err_pulses; rst mid-TRACK -> IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/count_result_checker_pkg.sv
// Shared types and defaults for the counter result-bus checker and the counter blocks it observes.
package count_result_checker_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StTrack,
    StRstChk,
    StFail
  } checker_state_t;

  // Result bus geometry shared with the reset-style counter blocks.
  localparam int unsigned CountWidth = 24;
  localparam logic [CountWidth-1:0] CountResetValue = '0;

endpackage

// File: rtl/count_result_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones once reached.
module count_result_checker_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/count_result_checker.sv
// Watches one free-running counter result bus: checks +1 per clock (with wrap) and that the
// counter sits at its reset value while its reset is applied.
module count_result_checker
  import count_result_checker_pkg::*;
#(
  parameter int unsigned     WIDTH       = CountWidth,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(CountResetValue),
  parameter int unsigned     ERR_CNT_W   = 16,
  parameter bit              STOP_ON_ERR = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 dut_rst_active_i,
  input  logic [WIDTH-1:0]     result_i,
  output logic                 locked_o,
  output logic                 err_pulse_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [WIDTH-1:0]     bad_value_o,
  output logic [WIDTH-1:0]     exp_value_o,
  output logic                 fail_o
);

  checker_state_t state_q, state_d;

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] mis_exp;
  logic             mismatch;
  // Set once the first (don't-care) cycle of a DUT reset window has passed.
  logic             rst_armed_q, rst_armed_d;
  logic             err_pulse_q;
  logic [WIDTH-1:0] bad_value_q, exp_value_q;

  // Carry is dropped so 2**WIDTH-1 wraps to 0.
  assign expected = prev_q + WIDTH'(1);

  // Mismatch detection; a DUT reset rising in TRACK masks any step error in that cycle.
  always_comb begin
    mismatch = 1'b0;
    mis_exp  = expected;
    if (en_i) begin
      unique case (state_q)
        StTrack: begin
          if (!dut_rst_active_i && (result_i != expected)) begin
            mismatch = 1'b1;
          end
        end
        StRstChk: begin
          if (dut_rst_active_i && rst_armed_q && (result_i != RESET_VALUE)) begin
            mismatch = 1'b1;
            mis_exp  = RESET_VALUE;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    rst_armed_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_i) state_d = StSync;
      end
      StSync, StTrack: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (dut_rst_active_i) begin
          state_d = StRstChk;
        end else if (mismatch) begin
          state_d = STOP_ON_ERR ? StFail : StSync;
        end else begin
          state_d = StTrack;
        end
      end
      StRstChk: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (!dut_rst_active_i) begin
          state_d = StSync;
        end else if (mismatch) begin
          state_d = STOP_ON_ERR ? StFail : StSync;
        end else begin
          rst_armed_d = 1'b1;
        end
      end
      StFail: ;
      default: state_d = StIdle;
    endcase
  end

  // Previous-sample capture: SYNC captures, TRACK follows the bus every cycle.
  always_comb begin
    prev_d = prev_q;
    if (en_i && ((state_q == StSync) || (state_q == StTrack))) begin
      prev_d = result_i;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      prev_q      <= '0;
      rst_armed_q <= 1'b0;
      err_pulse_q <= 1'b0;
      bad_value_q <= '0;
      exp_value_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      rst_armed_q <= rst_armed_d;
      err_pulse_q <= mismatch;
      if (mismatch) begin
        bad_value_q <= result_i;
        exp_value_q <= mis_exp;
      end
    end
  end

  count_result_checker_sat_counter #(
    .Width (ERR_CNT_W)
  ) u_err_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (mismatch),
    .count_o (err_count_o)
  );

  // State-decoded status outputs.
  always_comb begin
    locked_o = (state_q == StTrack);
    fail_o   = (state_q == StFail);
  end

  assign err_pulse_o = err_pulse_q;
  assign bad_value_o = bad_value_q;
  assign exp_value_o = exp_value_q;

endmodule

// File: tb/tb_count_result_checker.sv
// Bench for count_result_checker: three instances (default, stop-on-error, 2-bit error counter).
module tb_count_result_checker;

  typedef struct packed {
    logic [23:0] bad;
    logic [23:0] exp;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst [3];
  logic        en  [3];
  logic        dra [3];
  logic [23:0] res [3];

  logic        locked0, pulse0, fail0;
  logic [15:0] cnt0;
  logic [23:0] bad0, exp0;
  logic        locked1, pulse1, fail1;
  logic [15:0] cnt1;
  logic [23:0] bad1, exp1;
  logic        locked2, pulse2, fail2;
  logic [1:0]  cnt2;
  logic [23:0] bad2, exp2;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses0  = 0;
  int pulses1  = 0;
  int pulses2  = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  count_result_checker u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .en_i(en[0]), .dut_rst_active_i(dra[0]), .result_i(res[0]),
    .locked_o(locked0), .err_pulse_o(pulse0), .err_count_o(cnt0), .bad_value_o(bad0),
    .exp_value_o(exp0), .fail_o(fail0)
  );

  count_result_checker #(.STOP_ON_ERR(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .en_i(en[1]), .dut_rst_active_i(dra[1]), .result_i(res[1]),
    .locked_o(locked1), .err_pulse_o(pulse1), .err_count_o(cnt1), .bad_value_o(bad1),
    .exp_value_o(exp1), .fail_o(fail1)
  );

  count_result_checker #(.ERR_CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst[2]), .en_i(en[2]), .dut_rst_active_i(dra[2]), .result_i(res[2]),
    .locked_o(locked2), .err_pulse_o(pulse2), .err_count_o(cnt2), .bad_value_o(bad2),
    .exp_value_o(exp2), .fail_o(fail2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [23:0] b, input logic [23:0] e, input int c);
    exp_t t;
    t.bad = b;
    t.exp = e;
    t.cnt = 16'(c);
    return t;
  endfunction

  // Present one sample to instance d, let it be clocked in, return just after the edge.
  task automatic cyc(input int d, input logic [23:0] v, input logic r);
    res[d] = v;
    dra[d] = r;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop one expected error per observed err_pulse.
  always @(negedge clk) begin
    if (pulse0) begin
      exp_t e;
      pulses0++;
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut0 unexpected err_pulse: bad_value=%0h", bad0);
      end else begin
        e = q0.pop_front();
        chk("dut0 bad_value", 32'(bad0), 32'(e.bad));
        chk("dut0 exp_value", 32'(exp0), 32'(e.exp));
        chk("dut0 err_count", 32'(cnt0), 32'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (pulse1) begin
      exp_t e;
      pulses1++;
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected err_pulse: bad_value=%0h", bad1);
      end else begin
        e = q1.pop_front();
        chk("dut1 bad_value", 32'(bad1), 32'(e.bad));
        chk("dut1 exp_value", 32'(exp1), 32'(e.exp));
        chk("dut1 err_count", 32'(cnt1), 32'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (pulse2) begin
      exp_t e;
      pulses2++;
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut2 unexpected err_pulse: bad_value=%0h", bad2);
      end else begin
        e = q2.pop_front();
        chk("dut2 bad_value", 32'(bad2), 32'(e.bad));
        chk("dut2 exp_value", 32'(exp2), 32'(e.exp));
        chk("dut2 err_count", 32'(cnt2), 32'(e.cnt));
      end
    end
  end

  initial begin
    int drops;
    logic [23:0] v;
    logic [23:0] sat_bad [5];
    logic [23:0] sat_exp [5];
    int          sat_cnt [5];
    sat_bad = '{24'd10, 24'd20, 24'd30, 24'd40, 24'd50};
    sat_exp = '{24'd3, 24'd12, 24'd22, 24'd32, 24'd42};
    sat_cnt = '{1, 2, 3, 3, 3};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      en[d]  = 1'b0;
      dra[d] = 1'b0;
      res[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset locked", 32'(locked0), 0);
    chk("reset err_pulse", 32'(pulse0), 0);
    chk("reset err_count", 32'(cnt0), 0);
    chk("reset bad_value", 32'(bad0), 0);
    chk("reset exp_value", 32'(exp0), 0);
    chk("reset fail", 32'(fail0 | fail1 | fail2), 0);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // Clean ramp 0..1000.
    en[0] = 1'b1;
    drops = 0;
    for (int i = 0; i <= 1000; i++) begin
      cyc(0, 24'(i), 1'b0);
      if (i == 0) chk("ramp locked in sync", 32'(locked0), 0);
      else if (!locked0) drops++;
    end
    chk("ramp lock drops", 32'(drops), 0);
    chk("ramp err_count", 32'(cnt0), 0);

    // Wrap through 0xFFFFFF -> 0.
    en[0] = 1'b0;
    cyc(0, 24'd0, 1'b0);
    chk("en low unlocks", 32'(locked0), 0);
    en[0] = 1'b1;
    drops = 0;
    v = 24'hFFFFFD;
    for (int i = 0; i < 6; i++) begin
      cyc(0, v, 1'b0);
      if (i >= 1 && !locked0) drops++;
      v = v + 24'd1;
    end
    chk("wrap lock drops", 32'(drops), 0);
    chk("wrap err_count", 32'(cnt0), 0);

    // Skip 5,6,8.
    cyc(0, 24'd3, 1'b0);
    cyc(0, 24'd4, 1'b0);
    cyc(0, 24'd5, 1'b0);
    cyc(0, 24'd6, 1'b0);
    q0.push_back(mk(24'd8, 24'd7, 1));
    cyc(0, 24'd8, 1'b0);
    chk("skip unlocked", 32'(locked0), 0);
    cyc(0, 24'd9, 1'b0);
    chk("skip relocked", 32'(locked0), 1);
    cyc(0, 24'd10, 1'b0);
    cyc(0, 24'd11, 1'b0);
    chk("skip err_count", 32'(cnt0), 1);

    // DUT reset window; bogus value on reset rise must not flag.
    cyc(0, 24'd55, 1'b1);
    chk("rstchk unlocked", 32'(locked0), 0);
    cyc(0, 24'd0, 1'b1);
    cyc(0, 24'd0, 1'b1);
    cyc(0, 24'd0, 1'b1);
    cyc(0, 24'd0, 1'b0);
    cyc(0, 24'd1, 1'b0);
    cyc(0, 24'd2, 1'b0);
    chk("post-reset relock", 32'(locked0), 1);
    chk("clean reset err_count", 32'(cnt0), 1);

    // Non-reset value during DUT reset.
    cyc(0, 24'd3, 1'b0);
    cyc(0, 24'd99, 1'b1);
    cyc(0, 24'd0, 1'b1);
    q0.push_back(mk(24'd3, 24'd0, 2));
    cyc(0, 24'd3, 1'b1);
    chk("reset error unlocked", 32'(locked0), 0);
    cyc(0, 24'd0, 1'b1);
    cyc(0, 24'd0, 1'b0);
    cyc(0, 24'd1, 1'b0);
    cyc(0, 24'd2, 1'b0);
    chk("reset error relock", 32'(locked0), 1);

    // en low retains error state.
    en[0] = 1'b0;
    cyc(0, 24'd3, 1'b0);
    chk("en low locked", 32'(locked0), 0);
    chk("en low err_count", 32'(cnt0), 2);
    chk("en low bad_value", 32'(bad0), 3);
    chk("en low exp_value", 32'(exp0), 0);

    // Stop-on-error instance.
    en[1] = 1'b1;
    for (int i = 0; i <= 5; i++) cyc(1, 24'(i), 1'b0);
    q1.push_back(mk(24'd7, 24'd6, 1));
    cyc(1, 24'd7, 1'b0);
    chk("stop fail set", 32'(fail1), 1);
    chk("stop locked", 32'(locked1), 0);
    cyc(1, 24'd9, 1'b0);
    cyc(1, 24'd20, 1'b0);
    cyc(1, 24'd40, 1'b1);
    en[1] = 1'b0;
    cyc(1, 24'd41, 1'b0);
    chk("stop fail sticky", 32'(fail1), 1);
    chk("stop err_count frozen", 32'(cnt1), 1);
    chk("stop bad_value frozen", 32'(bad1), 7);
    chk("stop exp_value frozen", 32'(exp1), 6);
    rst[1] = 1'b1;
    cyc(1, 24'd0, 1'b0);
    rst[1] = 1'b0;
    chk("stop rst fail", 32'(fail1), 0);
    chk("stop rst err_count", 32'(cnt1), 0);
    chk("stop rst bad_value", 32'(bad1), 0);
    chk("stop rst exp_value", 32'(exp1), 0);

    // Saturation with a 2-bit error counter.
    en[2] = 1'b1;
    cyc(2, 24'd0, 1'b0);
    cyc(2, 24'd1, 1'b0);
    cyc(2, 24'd2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      q2.push_back(mk(sat_bad[k], sat_exp[k], sat_cnt[k]));
      cyc(2, sat_bad[k], 1'b0);
      cyc(2, sat_bad[k] + 24'd1, 1'b0);
    end
    cyc(2, 24'd52, 1'b0);
    chk("sat locked", 32'(locked2), 1);
    chk("sat err_count", 32'(cnt2), 3);
    rst[2] = 1'b1;
    cyc(2, 24'd53, 1'b0);
    rst[2] = 1'b0;
    chk("mid-track rst locked", 32'(locked2), 0);
    chk("mid-track rst err_count", 32'(cnt2), 0);
    chk("mid-track rst bad_value", 32'(bad2), 0);
    chk("mid-track rst exp_value", 32'(exp2), 0);
    chk("mid-track rst err_pulse", 32'(pulse2), 0);

    @(negedge clk);
    #1;
    chk("dut0 pulse total", 32'(pulses0), 2);
    chk("dut1 pulse total", 32'(pulses1), 1);
    chk("dut2 pulse total", 32'(pulses2), 5);
    chk("dut0 pending", 32'(q0.size()), 0);
    chk("dut1 pending", 32'(q1.size()), 0);
    chk("dut2 pending", 32'(q2.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
